// File: rtl/if_fetch_ctrl.sv
//============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction-fetch controller. Issues one instruction-memory
//               read per cycle under a credit rule, tracks the single read in
//               flight, and queues returned words with their addresses in a
//               2-entry output FIFO toward decode. A redirect flushes the
//               FIFO, squashes the in-flight read and restarts fetch at the
//               target address in the same cycle.
// Options     : FETCH_STALL_CNT_EN - adds the stall_cnt output: a saturating
//               count of cycles in which decode refused a valid head.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module if_fetch_ctrl #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk_im,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        redirect_en,
  input  logic [5:0]  redirect_addr,
  output logic [5:0]  IM_Addr,
  input  logic [31:0] Inst_Code,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [5:0]  inst_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned c_PC_W   = 6;
  localparam int unsigned c_INST_W = 32;
  localparam logic [1:0]  c_DEPTH  = 2'd2;

  // Fetch address and in-flight tracking
  logic [c_PC_W-1:0]   r_pc_next;
  logic                r_inflight;
  logic [c_PC_W-1:0]   r_inflight_pc;

  // Output FIFO storage and pointers
  logic [c_PC_W-1:0]   r_fifo_pc   [0:1];
  logic [c_INST_W-1:0] r_fifo_inst [0:1];
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  // Per-cycle control decisions
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic                w_credit_ok;
  logic [2:0]          w_fill;
  logic                w_wr_ptr;
  logic [1:0]          w_count_nxt;
  logic                w_rd_ptr_nxt;

  // Head of the FIFO is what decode sees
  assign inst_valid = (r_count != 2'd0);
  assign inst_out   = r_fifo_inst[r_rd_ptr];
  assign inst_pc    = r_fifo_pc[r_rd_ptr];

  // Handshake, push and issue decisions for the current cycle
  always_comb begin
    w_pop       = inst_valid & inst_ready;
    // A redirect squashes whatever is returning this cycle
    w_push      = rst_n & r_inflight & ~redirect_en;
    // Occupancy the FIFO will have once this cycle's pop and pending
    // return are accounted for; a new read is only safe if a slot remains.
    w_fill      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_credit_ok = (w_fill < {1'b0, c_DEPTH});
    // A redirect issues its target regardless of credit because the flush
    // frees every slot in the same edge.
    w_issue     = rst_n & run_en & (redirect_en | w_credit_ok);
    // Tail slot is the one after the head when one entry is held
    w_wr_ptr    = r_rd_ptr ^ r_count[0];
  end

  // Address presented to the instruction memory
  always_comb begin
    IM_Addr = r_pc_next;
    if (!rst_n) begin
      IM_Addr = RESET_PC;
    end else if (redirect_en && run_en) begin
      IM_Addr = redirect_addr;
    end
  end

  // FIFO pointer/count next state; a redirect empties the queue outright
  always_comb begin
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    if (redirect_en) begin
      w_count_nxt  = 2'd0;
      w_rd_ptr_nxt = 1'b0;
    end else begin
      if (w_pop) begin
        w_rd_ptr_nxt = ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Fetch address sequencing and in-flight read tracking
  always_ff @(posedge clk_im) begin
    if (!rst_n) begin
      r_pc_next     <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        // IM_Addr already carries the redirect target when one is issued,
        // so both sequential and redirected fetch advance from it.
        r_inflight_pc <= IM_Addr;
        r_pc_next     <= IM_Addr + 6'd1;
      end else if (redirect_en) begin
        // Redirect while halted: remember the target for the next issue
        r_pc_next <= redirect_addr;
      end
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk_im) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // FIFO data storage; contents are qualified by r_count so need no reset
  always_ff @(posedge clk_im) begin
    if (w_push) begin
      r_fifo_pc[w_wr_ptr]   <= r_inflight_pc;
      r_fifo_inst[w_wr_ptr] <= Inst_Code;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  assign stall_cnt = r_stall_cnt;

  // Saturating count of back-pressure cycles; survives redirects
  always_ff @(posedge clk_im) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (inst_valid && !inst_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
